// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate generator with a 2-entry skid buffer.
// Accepts instruction + tag over valid/ready and emits a sign-extended immediate,
// a format code and an illegal-opcode flag one cycle after accept.
// Optional macro IMMGEN_ZICSR_EN: decode SYSTEM opcode (CSR immediates) as legal
// I/Z formats; when undefined, SYSTEM passes through as NONE and legal.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] FmtZ    = 3'd6;
`endif

    state_e            state_q, state_d;
    logic [XLEN-1:0]   out_imm_q, out_imm_d;
    logic [2:0]        out_fmt_q, out_fmt_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_illegal_q, out_illegal_d;
    logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
    logic [2:0]        skid_fmt_q, skid_fmt_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
    logic              skid_illegal_q, skid_illegal_d;

    logic [31:0]       dec_imm32;
    logic [XLEN-1:0]   dec_imm;
    logic [2:0]        dec_fmt;
    logic              dec_illegal;
    logic              in_fire, out_fire;

    // Combinational decode of the incoming instruction word into a 32-bit immediate.
    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = FmtNone;
        dec_illegal = 1'b0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_fmt   = FmtI;
            end
            7'b0100011: begin
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec_fmt   = FmtS;
            end
            7'b1100011: begin
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
                dec_fmt   = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {in_inst[31:12], 12'b0};
                dec_fmt   = FmtU;
            end
            7'b1101111: begin
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
                dec_fmt   = FmtJ;
            end
            7'b0110011: begin
                dec_fmt = FmtNone;
            end
            7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                if (in_inst[14]) begin
                    dec_imm32 = {27'b0, in_inst[19:15]};
                    dec_fmt   = FmtZ;
                end else begin
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    dec_fmt   = FmtI;
                end
`else
                // ecall/ebreak and CSR ops pass through without an immediate.
                dec_fmt = FmtNone;
`endif
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Sign extension of the 32-bit immediate to XLEN (zimm has bit 31 clear).
    assign dec_imm = XLEN'($signed(dec_imm32));

    // in_ready depends only on registered state and reset, never on out_ready.
    assign in_ready  = (state_q != StFull) && !reset;
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

    // Next-state: skid buffer occupancy and data movement between input, skid and output.
    always_comb begin
        state_d        = state_q;
        out_imm_d      = out_imm_q;
        out_fmt_d      = out_fmt_q;
        out_tag_d      = out_tag_q;
        out_illegal_d  = out_illegal_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_tag_d     = skid_tag_q;
        skid_illegal_d = skid_illegal_q;
        case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    out_imm_d     = dec_imm;
                    out_fmt_d     = dec_fmt;
                    out_tag_d     = in_tag;
                    out_illegal_d = dec_illegal;
                    state_d       = StOne;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    out_imm_d     = dec_imm;
                    out_fmt_d     = dec_fmt;
                    out_tag_d     = in_tag;
                    out_illegal_d = dec_illegal;
                end else if (in_fire) begin
                    skid_imm_d     = dec_imm;
                    skid_fmt_d     = dec_fmt;
                    skid_tag_d     = in_tag;
                    skid_illegal_d = dec_illegal;
                    state_d        = StFull;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    out_imm_d      = skid_imm_q;
                    out_fmt_d      = skid_fmt_q;
                    out_tag_d      = skid_tag_q;
                    out_illegal_d  = skid_illegal_q;
                    skid_imm_d     = '0;
                    skid_fmt_d     = '0;
                    skid_tag_d     = '0;
                    skid_illegal_d = 1'b0;
                    state_d        = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops everything still buffered, including a same-cycle accept.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StEmpty;
            out_imm_q      <= '0;
            out_fmt_q      <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_imm_q      <= out_imm_d;
            out_fmt_q      <= out_fmt_d;
            out_tag_q      <= out_tag_d;
            out_illegal_q  <= out_illegal_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_tag_q     <= skid_tag_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one input stream and
// are checked every cycle against a queue-based reference of the stage contents.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_tag32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_fmt64;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
        logic        ill;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32),
        .out_illegal(out_illegal32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64),
        .out_illegal(out_illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode using signed arithmetic on the immediate fields.
    function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] tag);
        ent_t   e;
        longint v = 0;
        logic   s = inst[31];
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = longint'(inst[30:20]) - (s ? 2048 : 0); e.fmt = 3'd1;
            end
            7'h23: begin
                v = longint'(inst[30:25]) * 32 + longint'(inst[11:7]) - (s ? 2048 : 0);
                e.fmt = 3'd2;
            end
            7'h63: begin
                v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                    + longint'(inst[11:8]) * 2 - (s ? 4096 : 0);
                e.fmt = 3'd3;
            end
            7'h37, 7'h17: begin
                v = longint'(inst[30:12]) * 4096 - (s ? 64'sh8000_0000 : 0); e.fmt = 3'd4;
            end
            7'h6f: begin
                v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                    + longint'(inst[30:21]) * 2 - (s ? 1048576 : 0);
                e.fmt = 3'd5;
            end
            7'h33: v = 0;
            7'h73: begin
`ifdef IMMGEN_ZICSR_EN
                if (inst[14]) begin
                    v = longint'(inst[19:15]); e.fmt = 3'd6;
                end else begin
                    v = longint'(inst[30:20]) - (s ? 2048 : 0); e.fmt = 3'd1;
                end
`else
                v = 0;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        e.tag = tag;
        return e;
    endfunction

    // One clock: check outputs at negedge, then advance the reference across the edge.
    task automatic cycle();
        logic exp_ready, exp_valid, in_fire, out_fire;
        ent_t e;
        @(negedge clk);
        exp_ready = !reset && (q.size() < 2);
        exp_valid = (q.size() > 0);
        chk("in_ready32", {63'b0, in_ready32}, {63'b0, exp_ready});
        chk("in_ready64", {63'b0, in_ready64}, {63'b0, exp_ready});
        chk("out_valid32", {63'b0, out_valid32}, {63'b0, exp_valid});
        chk("out_valid64", {63'b0, out_valid64}, {63'b0, exp_valid});
        if (exp_valid) begin
            e = q[0];
            chk("imm32", {32'b0, out_imm32}, {32'b0, e.imm[31:0]});
            chk("imm64", out_imm64, e.imm);
            chk("fmt32", {61'b0, out_fmt32}, {61'b0, e.fmt});
            chk("fmt64", {61'b0, out_fmt64}, {61'b0, e.fmt});
            chk("tag32", {32'b0, out_tag32}, {32'b0, e.tag});
            chk("tag64", {32'b0, out_tag64}, {32'b0, e.tag});
            chk("ill32", {63'b0, out_illegal32}, {63'b0, e.ill});
            chk("ill64", {63'b0, out_illegal64}, {63'b0, e.ill});
        end
        in_fire  = in_valid && exp_ready;
        out_fire = out_ready && exp_valid;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(ref_decode(in_inst, in_tag));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                         input logic rdy);
        in_valid  = v;
        in_inst   = inst;
        in_tag    = tag;
        out_ready = rdy;
    endtask

    logic [31:0] opcodes [12] = '{32'h13, 32'h03, 32'h67, 32'h23, 32'h63, 32'h37,
                                  32'h17, 32'h6f, 32'h33, 32'h73, 32'h7f, 32'h0b};

    initial begin
        logic [31:0] r, op;
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        // Reset values of the output registers.
        chk("rst_imm32", {32'b0, out_imm32}, 64'h0);
        chk("rst_imm64", out_imm64, 64'h0);
        chk("rst_fmt", {61'b0, out_fmt32}, 64'h0);
        chk("rst_tag", {32'b0, out_tag32}, 64'h0);
        chk("rst_ill", {63'b0, out_illegal64}, 64'h0);

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h10, 1'b1); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("addi_imm32", {32'b0, out_imm32}, 64'hFFFF_FFFF);
        chk("addi_fmt", {61'b0, out_fmt32}, 64'd1);
        cycle();

        // beq -4 then lui back-to-back
        drive(1'b1, 32'hFE000EE3, 32'h20, 1'b1); cycle();
        chk("beq_imm32", {32'b0, out_imm32}, 64'hFFFF_FFFC);
        chk("beq_fmt", {61'b0, out_fmt32}, 64'd3);
        drive(1'b1, 32'h123450B7, 32'h21, 1'b1); cycle();
        chk("lui_imm32", {32'b0, out_imm32}, 64'h1234_5000);
        chk("lui_fmt", {61'b0, out_fmt32}, 64'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1); cycle();

        // Backpressure: tags 1,2,3 with out_ready low, then drain.
        drive(1'b1, 32'h00500113, 32'd1, 1'b0); cycle();
        drive(1'b1, 32'h00A00193, 32'd2, 1'b0); cycle();
        drive(1'b1, 32'h00F00213, 32'd3, 1'b0); cycle();
        chk("bp_tag_hold", {32'b0, out_tag32}, 64'd1);
        chk("bp_full", {63'b0, in_ready32}, 64'd0);
        cycle();
        drive(1'b1, 32'h00F00213, 32'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) in_valid = 1'b0;
            cycle();
        end

        // Flush while FULL with a valid input in the flush cycle.
        drive(1'b1, 32'h00000013, 32'd7, 1'b0); cycle();
        drive(1'b1, 32'h00100013, 32'd8, 1'b0); cycle();
        drive(1'b1, 32'h00200013, 32'd9, 1'b0); flush = 1'b1; cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("flush_valid", {63'b0, out_valid32}, 64'd0);
        chk("flush_ready", {63'b0, in_ready64}, 64'd1);
        cycle();

        // XLEN=64 U sign replication and illegal opcode.
        drive(1'b1, 32'h800000B7, 32'd11, 1'b1); cycle();
        chk("lui64_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
        drive(1'b1, 32'h0000007F, 32'd12, 1'b1); cycle();
        chk("illegal_flag", {63'b0, out_illegal64}, 64'd1);
        chk("illegal_fmt", {61'b0, out_fmt64}, 64'd0);
        // csrrwi x0,0x300,31
        drive(1'b1, 32'h300FD073, 32'd13, 1'b1); cycle();
`ifdef IMMGEN_ZICSR_EN
        chk("csr_imm", out_imm64, 64'h1F);
        chk("csr_fmt", {61'b0, out_fmt64}, 64'd6);
`else
        chk("csr_imm", out_imm64, 64'h0);
        chk("csr_fmt", {61'b0, out_fmt64}, 64'd0);
`endif
        chk("csr_ill", {63'b0, out_illegal64}, 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1); cycle();

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            r  = $urandom();
            op = opcodes[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = {25'b0, r[6:0]};
            drive(($urandom_range(0, 3) != 0), {r[31:7], op[6:0]}, $urandom(),
                  ($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
